// File: rtl/gray_counter_mod.sv
// gray_counter_mod
// ----------------
// Modulo-MODULO up/down counter that moves by STEP on each enabled cycle.
// The binary count and its Gray code are both registered. The counter has
// an enable, a direction input, a synchronous load, and two end-of-range
// policies: wrap or saturate. It is meant as a pointer or sequence source,
// for example FIFO pointers or counts that cross clock domains.
//
// Parameters
//   WIDTH      counter width in bits; MODULO <= 2**WIDTH
//   MODULO     count range is 0..MODULO-1; MODULO >= 2
//   STEP       amount added or subtracted per enabled cycle; 1 <= STEP < MODULO
//   SATURATE   0: wrap modulo MODULO; 1: clamp at 0 or MODULO-1
//   RESET_VAL  value after reset; must be < MODULO
//
// Ports
//   clk_i       in   1      clock, rising edge
//   rst_i       in   1      asynchronous reset, active-low
//   en_i        in   1      count enable
//   up_i        in   1      direction: 1 = up, 0 = down
//   load_i      in   1      synchronous load strobe (has priority over en_i)
//   load_val_i  in   WIDTH  binary value to load; clamped to MODULO-1
//   bin_o       out  WIDTH  registered binary count
//   gray_o      out  WIDTH  registered Gray code of bin_o
//   limit_o     out  1      1-cycle pulse on a wrap or a clamp
//   load_err_o  out  1      1-cycle pulse when a load value was clamped
//
// Every output is registered. The edge that samples a command updates all
// of them together.

module gray_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 10,
  parameter int STEP      = 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             limit_o,
  output logic             load_err_o
);

  // Parameter sanity checks, evaluated at elaboration time.
  if (MODULO < 2) begin : g_chk_mod_min
    $error("gray_counter_mod: MODULO must be >= 2");
  end
  if (MODULO > (2 ** WIDTH)) begin : g_chk_mod_max
    $error("gray_counter_mod: MODULO must be <= 2**WIDTH");
  end
  if ((STEP < 1) || (STEP >= MODULO)) begin : g_chk_step
    $error("gray_counter_mod: STEP must satisfy 1 <= STEP < MODULO");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULO)) begin : g_chk_rst
    $error("gray_counter_mod: RESET_VAL must be < MODULO");
  end

  // The arithmetic uses one extra bit. With it, cnt+STEP and
  // cnt+MODULO-STEP cannot overflow, even when MODULO == 2**WIDTH.
  localparam int W1 = WIDTH + 1;

  localparam logic [W1-1:0]    MOD_EXT  = W1'(MODULO);
  localparam logic [W1-1:0]    STEP_EXT = W1'(STEP);
  localparam logic [W1-1:0]    MAX_EXT  = W1'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             limit_q;
  logic             load_err_q;

  logic [W1-1:0]    cnt_ext;
  logic [W1-1:0]    sum_ext;
  logic [W1-1:0]    load_ext;
  logic [W1-1:0]    next_ext;
  logic             next_limit;
  logic             next_load_err;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             unused_next_msb;

  assign cnt_ext  = {1'b0, bin_q};
  assign sum_ext  = cnt_ext + STEP_EXT;
  assign load_ext = {1'b0, load_val_i};

  // Next-state selection. The priority is load, then count, then hold.
  always_comb begin
    next_ext      = cnt_ext;
    next_limit    = 1'b0;
    next_load_err = 1'b0;
    if (load_i) begin
      if (load_ext >= MOD_EXT) begin
        next_ext      = MAX_EXT;
        next_load_err = 1'b1;
      end else begin
        next_ext = load_ext;
      end
    end else if (en_i) begin
      if (SATURATE != 0) begin
        // A clamp pulses limit even when the count already sits at the end.
        if (up_i) begin
          if (sum_ext > MAX_EXT) begin
            next_ext   = MAX_EXT;
            next_limit = 1'b1;
          end else begin
            next_ext = sum_ext;
          end
        end else begin
          if (cnt_ext < STEP_EXT) begin
            next_ext   = '0;
            next_limit = 1'b1;
          end else begin
            next_ext = cnt_ext - STEP_EXT;
          end
        end
      end else begin
        if (up_i) begin
          if (sum_ext >= MOD_EXT) begin
            next_ext   = sum_ext - MOD_EXT;
            next_limit = 1'b1;
          end else begin
            next_ext = sum_ext;
          end
        end else begin
          if (cnt_ext < STEP_EXT) begin
            next_ext   = cnt_ext + MOD_EXT - STEP_EXT;
            next_limit = 1'b1;
          end else begin
            next_ext = cnt_ext - STEP_EXT;
          end
        end
      end
    end
  end

  // Every result is below MODULO, so the extra bit is always zero here.
  assign next_bin        = next_ext[WIDTH-1:0];
  assign unused_next_msb = next_ext[WIDTH];

  // The Gray code is computed from the next binary value and then
  // registered. Decoding it after the bin_q register instead could glitch.
  assign next_gray = next_bin ^ (next_bin >> 1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bin_q      <= RST_BIN;
      gray_q     <= RST_GRAY;
      limit_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bin_q      <= next_bin;
      gray_q     <= next_gray;
      limit_q    <= next_limit;
      load_err_q <= next_load_err;
    end
  end

  assign bin_o      = bin_q;
  assign gray_o     = gray_q;
  assign limit_o    = limit_q;
  assign load_err_o = load_err_q;

endmodule
